// File: rtl/calculation_pipe_if.sv
// Handshake bundle for calculation_pipe: operand input channel and result output channel.
// master drives operands and out_ready; slave is the pipe itself.
`timescale 1ns/1ps
interface calculation_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] f;
  logic             neg;

  modport master (
    output in_valid, a, b, c, d, mode, out_ready,
    input  in_ready, out_valid, f, neg
  );

  modport slave (
    input  in_valid, a, b, c, d, mode, out_ready,
    output in_ready, out_valid, f, neg
  );
endinterface

// File: rtl/calculation_pipe.sv
// Two-stage valid/ready pipe computing (a+b) -/+ (c+d) with a negative flag.
// Optional macro CALCULATION_PIPE_CLAMP_EN floors negative mode-0 results to zero.
`timescale 1ns/1ps
module calculation_pipe #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  calculation_pipe_if.slave  bus
);
  localparam int SW = WIDTH + 1;
  localparam int FW = WIDTH + 2;
`ifdef CALCULATION_PIPE_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  logic          vld_p1;
  logic [SW-1:0] sum1_p1;
  logic [SW-1:0] sum2_p1;
  logic          mode_p1;

  logic          vld_p2;
  logic [FW-1:0] f_p2;
  logic          neg_p2;

  logic          ld_p1;
  logic          ld_p2;
  logic signed [FW-1:0] res_s;
  logic          neg_s;
  logic [FW-1:0] f_s;

  // Both sums are widened by one zero bit so the difference of two SW-bit
  // values always fits a signed FW-bit result without overflow.
  function automatic logic signed [FW-1:0] combine(
    input logic [SW-1:0] s1,
    input logic [SW-1:0] s2,
    input logic          m
  );
    logic signed [FW-1:0] x1;
    logic signed [FW-1:0] x2;
    x1 = signed'({1'b0, s1});
    x2 = signed'({1'b0, s2});
    return m ? (x1 + x2) : (x1 - x2);
  endfunction

  function automatic logic [FW-1:0] floor_clamp(
    input logic signed [FW-1:0] x,
    input logic                 n
  );
    return (CLAMP_EN && n) ? '0 : unsigned'(x);
  endfunction

  assign ld_p2  = vld_p1 && (!vld_p2 || bus.out_ready);
  assign ld_p1  = !vld_p1 || ld_p2;

  // Sign bit is only meaningful for the subtraction; mode 1 sums can use it as magnitude.
  assign res_s  = combine(sum1_p1, sum2_p1, mode_p1);
  assign neg_s  = !mode_p1 && res_s[FW-1];
  assign f_s    = floor_clamp(res_s, neg_s);

  assign bus.in_ready  = ld_p1;
  assign bus.out_valid = vld_p2;
  assign bus.f         = f_p2;
  assign bus.neg       = neg_p2;

  // ---- stage 1: operand pair sums ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sum1_p1 <= '0;
      sum2_p1 <= '0;
      mode_p1 <= 1'b0;
    end else if (ld_p1) begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        sum1_p1 <= {1'b0, bus.a} + {1'b0, bus.b};
        sum2_p1 <= {1'b0, bus.c} + {1'b0, bus.d};
        mode_p1 <= bus.mode;
      end
    end
  end

  // ---- stage 2: combined result and sign flag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      f_p2   <= '0;
      neg_p2 <= 1'b0;
    end else if (ld_p2) begin
      vld_p2 <= 1'b1;
      f_p2   <= f_s;
      neg_p2 <= neg_s;
    end else if (bus.out_ready) begin
      vld_p2 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_calculation_pipe.sv
// Self-checking bench for calculation_pipe (WIDTH=4): vector table, scoreboard,
// backpressure, mid-stream reset and random streaming sequences.
`timescale 1ns/1ps
module tb_calculation_pipe;
  localparam int WIDTH = 4;
  localparam int FW    = WIDTH + 2;
`ifdef CALCULATION_PIPE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam int NV = 12;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             mode;
    logic [FW-1:0]    f;
    logic             neg;
  } vec_t;

  typedef struct {
    logic [FW-1:0] f;
    logic          neg;
    int            cyc;
    bit            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  calculation_pipe_if #(.WIDTH(WIDTH)) bus ();
  calculation_pipe #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  vec_t          tbl[NV];
  exp_t          sb[$];
  int            pop_log[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            lat_on = 1'b0;
  logic [FW-1:0] cur_f;
  logic          cur_neg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int a, input int b, input int c, input int d,
                                input bit m, output logic [FW-1:0] f, output logic n);
    int s;
    if (m) begin
      f = FW'(a + b + c + d);
      n = 1'b0;
    end else begin
      s = (a + b) - (c + d);
      n = (s < 0);
      f = (n && CLAMP) ? '0 : FW'(s + (1 << FW));
    end
  endfunction

  task automatic present_exp(input int a, input int b, input int c, input int d,
                             input bit m, input logic [FW-1:0] ef, input logic en);
    bus.a = WIDTH'(a); bus.b = WIDTH'(b); bus.c = WIDTH'(c); bus.d = WIDTH'(d);
    bus.mode = m;
    cur_f = ef;
    cur_neg = en;
    bus.in_valid = 1'b1;
  endtask

  task automatic present(input int a, input int b, input int c, input int d, input bit m);
    logic [FW-1:0] ef;
    logic          en;
    model(a, b, c, d, m, ef, en);
    present_exp(a, b, c, d, m, ef, en);
  endtask

  // Returns one time unit after the edge on which the presented item transferred.
  task automatic accept_wait();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t          e;
    bit            hold = 1'b0;
    logic [FW-1:0] hf = '0;
    logic          hn = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_f", bus.f, hf);
        check("hold_neg", bus.neg, hn);
      end
      hold = bus.out_valid && !bus.out_ready;
      hf = bus.f;
      hn = bus.neg;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", bus.out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("sb_f", bus.f, e.f);
          check("sb_neg", bus.neg, e.neg);
          if (e.lat) check("latency", cyc - e.cyc, 2);
          pop_log.push_back(cyc);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.f = cur_f;
        e.neg = cur_neg;
        e.cyc = cyc;
        e.lat = lat_on;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [FW-1:0] ef;

    //          a      b      c      d      mode  f(wrapped) neg
    tbl[0]  = '{4'd9,  4'd6,  4'd2,  4'd3,  1'b0, 6'd10, 1'b0};
    tbl[1]  = '{4'd1,  4'd0,  4'd15, 4'd15, 1'b0, 6'd35, 1'b1};
    tbl[2]  = '{4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 6'd60, 1'b0};
    tbl[3]  = '{4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 6'd0,  1'b0};
    tbl[4]  = '{4'd0,  4'd0,  4'd0,  4'd0,  1'b1, 6'd0,  1'b0};
    tbl[5]  = '{4'd15, 4'd15, 4'd0,  4'd0,  1'b0, 6'd30, 1'b0};
    tbl[6]  = '{4'd0,  4'd0,  4'd15, 4'd15, 1'b0, 6'd34, 1'b1};
    tbl[7]  = '{4'd7,  4'd7,  4'd7,  4'd8,  1'b0, 6'd63, 1'b1};
    tbl[8]  = '{4'd3,  4'd4,  4'd5,  4'd2,  1'b0, 6'd0,  1'b0};
    tbl[9]  = '{4'd1,  4'd2,  4'd3,  4'd4,  1'b1, 6'd10, 1'b0};
    tbl[10] = '{4'd15, 4'd0,  4'd0,  4'd15, 1'b0, 6'd0,  1'b0};
    tbl[11] = '{4'd8,  4'd8,  4'd1,  4'd0,  1'b1, 6'd17, 1'b0};

    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.mode = 1'b0;
    bus.out_ready = 1'b0;
    cur_f = '0;
    cur_neg = 1'b0;
    rst = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_f", bus.f, 0);
    check("rst_neg", bus.neg, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("in_ready_after_rst", bus.in_ready, 1);

    // Basic subtract, two-edge latency
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    lat_on = 1'b1;
    present_exp(9, 6, 2, 3, 1'b0, 6'd10, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("basic_edge1_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("basic_edge2_valid", bus.out_valid, 1);
    check("basic_f", bus.f, 10);
    check("basic_neg", bus.neg, 0);

    // Vector table, streamed back-to-back
    for (int i = 0; i < NV; i++) begin
      ef = (tbl[i].neg && CLAMP) ? '0 : tbl[i].f;
      present_exp(int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].c), int'(tbl[i].d),
                  tbl[i].mode, ef, tbl[i].neg);
      accept_wait();
    end
    bus.in_valid = 1'b0;
    wait_drain();

    // Backpressure: two fill the pipe, the third must stall
    lat_on = 1'b0;
    bus.out_ready = 1'b0;
    present(1, 2, 3, 4, 1'b0);
    accept_wait();
    present(5, 5, 1, 1, 1'b1);
    accept_wait();
    present(9, 9, 2, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
    pop_log.delete();
    bus.out_ready = 1'b1;
    accept_wait();
    present(15, 15, 15, 0, 1'b1);
    accept_wait();
    bus.in_valid = 1'b0;
    wait_drain();
    check("bp_count", pop_log.size(), 4);
    if (pop_log.size() == 4) check("bp_back_to_back", pop_log[3] - pop_log[0], 3);

    // Asynchronous reset with both stages occupied
    bus.out_ready = 1'b0;
    present(2, 2, 1, 1, 1'b0);
    accept_wait();
    present(3, 3, 3, 3, 1'b1);
    accept_wait();
    bus.in_valid = 1'b0;
    check("pre_rst_out_valid", bus.out_valid, 1);
    check("pre_rst_in_ready", bus.in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_f", bus.f, 0);
    check("mid_rst_neg", bus.neg, 0);
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("mid_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("no_stale_output", cnt, 0);

    // Random streaming, both modes
    @(posedge clk);
    #1;
    lat_on = 1'b1;
    pop_log.delete();
    for (int i = 0; i < 16; i++) begin
      present($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), (i % 3) == 1);
      accept_wait();
    end
    bus.in_valid = 1'b0;
    wait_drain();
    check("stream_count", pop_log.size(), 16);
    if (pop_log.size() == 16) check("stream_back_to_back", pop_log[15] - pop_log[0], 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
